uart_tx_scheduler: RTL and testbench
====================================

// Module: uart_tx_scheduler
// PURPOSE
//  Shares the single UART transmitter between two byte sources: req0 (RX echo path) and req1 (processor/Nios PIO).
//  Round-robin arbitration; level handshake to uart_tx, which runs on the divided clock.
//  Sequences serial-mode reconfiguration (speed/parity byte from processor) so cfg changes land only between frames.
//  Sits between control_uart/processor and uart_tx/clk_divider.
// PARAMETERS
//  BUSY_TIMEOUT   4096  clk cycles allowed for tx_busy to rise after tx_start; exceeded -> abort, err_timeout
//  SETTLE_CYCLES  16    clk cycles held after cfg_pulse before next grant (divider relock)
// PORTS
//  clk          in   1  system clock (50 MHz domain)
//  reset        in   1  asynchronous, active-low reset
//  req0_valid   in   1  source 0 has byte
//  req0_data    in   8  source 0 byte
//  req0_ready   out  1  1-cycle accept strobe for source 0
//  req1_valid   in   1  source 1 has byte
//  req1_data    in   8  source 1 byte
//  req1_ready   out  1  1-cycle accept strobe for source 1
//  tx_data      out  8  byte presented to uart_tx, stable START..WAIT_DONE
//  tx_start     out  1  level request to uart_tx, held until busy seen
//  tx_busy      in   1  uart_tx shifting (clk_speed domain; 2-flop synced here)
//  cfg_in       in   8  requested mode byte ([7:6] frame cfg, [5:4] speed)
//  cfg_out      out  8  applied mode byte to uart_rx/uart_tx/clk_divider
//  cfg_pulse    out  1  1-cycle strobe when cfg_out updates
//  grant        out  2  one-hot owner of current frame, 00 when idle
//  err_timeout  out  1  sticky; set on busy timeout, cleared by reset only
//  count0       out 16  frames sent for source 0 (see CONFIGURATION)
//  count1       out 16  frames sent for source 1
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; rr pointer -> req0 first; cfg_out=8'h00.
//  Handshake: byte transferred when reqN_valid & reqN_ready; ready only in IDLE, only to winner.
//  FSM:
//   IDLE:      if cfg_in != cfg_out -> CFG (cfg has priority over bytes).
//              else if any valid -> grant by rr (last-served loses tie), latch data, ready=1, -> START.
//   START:     tx_start=1 until busy_s=1 -> WAIT_DONE; timer>=BUSY_TIMEOUT -> err_timeout=1, tx_start=0, -> IDLE.
//   WAIT_DONE: tx_start=0; busy_s falls -> count++, rr pointer <- winner, grant=00, -> IDLE.
//   CFG:       cfg_out<=cfg_in, cfg_pulse=1 for 1 cycle, -> SETTLE.
//   SETTLE:    hold SETTLE_CYCLES cycles, no grants -> IDLE.
//  Latency: valid in IDLE -> ready same cycle (combinational from state+valid); tx_start next cycle.
//  Only one owner at a time; grant stays one-hot from START through WAIT_DONE.
//  cfg_in change during frame: deferred until WAIT_DONE completes; intermediate values ignored, latest wins.
//  cfg_in change during SETTLE: re-evaluated on return to IDLE (new CFG pass).
//  Both valid in same cycle: rr alternates; continuous traffic on both -> strict alternation.
//  Timeout abort: byte dropped, not retried; counters not incremented.
//  Counters wrap 16'hFFFF -> 0.
//  reset low mid-frame: immediate return to reset values; tx_start drops asynchronously.
// CONFIGURATION
//  UART_SCHED_STATS_EN defined: count0/count1 implemented as above.
//  Not defined: counters absent, count0/count1 tied 16'h0000; all else identical.
// TESTING
//  req0 byte 8'h41, tx_busy 10 cycles after start -> tx_data=41, grant=01, count0=1, back to IDLE.
//  req0,req1 valid together 4 frames -> order req0,req1,req0,req1; ready strobes alternate.
//  cfg_in 00->C0 mid-frame -> cfg_pulse after busy falls, cfg_out=C0, no grant for 16 cycles.
//  tx_busy never rises, BUSY_TIMEOUT=32 -> tx_start drops at cycle 32, err_timeout=1, no count.
//  reset asserted in WAIT_DONE -> all outputs 0, next grant goes to req0.
//  Without UART_SCHED_STATS_EN, 3 frames -> count0=count1=0, traffic otherwise identical.

Source files
------------

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART transmitter between two byte sources, with
// between-frame mode reconfiguration. Define UART_SCHED_STATS_EN to build the frame counters.
module uart_tx_scheduler #(
  parameter int BUSY_TIMEOUT  = 4096,
  parameter int SETTLE_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic [7:0]  req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [7:0]  req1_data,
  output logic        req1_ready,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  input  logic        tx_busy,
  input  logic [7:0]  cfg_in,
  output logic [7:0]  cfg_out,
  output logic        cfg_pulse,
  output logic [1:0]  grant,
  output logic        err_timeout,
  output logic [15:0] count0,
  output logic [15:0] count1,
  output logic [2:0]  dbg_state
);

  localparam int TW = $clog2(BUSY_TIMEOUT + 1);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [TW-1:0] TIMER_LAST  = TW'(BUSY_TIMEOUT - 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    WAIT_DONE = 3'd2,
    CFG       = 3'd3,
    SETTLE    = 3'd4
  } state_t;

  state_t        state, state_nxt;
  logic          busy_m, busy_s;
  logic [TW-1:0] timer;
  logic [SW-1:0] settle_cnt;
  logic          rr_last;   // source served by the last completed frame (1 = req1)
  logic          pick1;

  // Handshake: a byte moves on a cycle where reqN_valid & reqN_ready; ready is raised
  // only in IDLE, only to the arbitration winner, and only while that source is valid.
  always_comb begin
    state_nxt  = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    pick1      = req1_valid && (!req0_valid || !rr_last);
    case (state)
      IDLE: begin
        if (cfg_in != cfg_out) begin
          state_nxt = CFG;
        end else if (req0_valid || req1_valid) begin
          state_nxt  = START;
          req0_ready = !pick1;
          req1_ready = pick1;
        end
      end
      START: begin
        if (busy_s)                   state_nxt = WAIT_DONE;
        else if (timer >= TIMER_LAST) state_nxt = IDLE;
      end
      WAIT_DONE: if (!busy_s) state_nxt = IDLE;
      CFG:       state_nxt = SETTLE;
      SETTLE:    if (settle_cnt == SETTLE_LAST) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Derived from state so that an asynchronous reset drops it immediately.
  assign tx_start  = (state == START);
  assign dbg_state = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      busy_m      <= 1'b0;
      busy_s      <= 1'b0;
      timer       <= '0;
      settle_cnt  <= '0;
      rr_last     <= 1'b1;
      tx_data     <= 8'h00;
      grant       <= 2'b00;
      cfg_out     <= 8'h00;
      cfg_pulse   <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      state      <= state_nxt;
      busy_m     <= tx_busy;
      busy_s     <= busy_m;
      cfg_pulse  <= 1'b0;
      timer      <= (state == START)  ? timer + 1'b1      : '0;
      settle_cnt <= (state == SETTLE) ? settle_cnt + 1'b1 : '0;
      case (state)
        IDLE: begin
          if (req0_ready || req1_ready) begin
            tx_data <= pick1 ? req1_data : req0_data;
            grant   <= pick1 ? 2'b10 : 2'b01;
          end
        end
        START: begin
          // Aborted byte is dropped; rr pointer keeps its previous owner.
          if (!busy_s && timer >= TIMER_LAST) begin
            err_timeout <= 1'b1;
            grant       <= 2'b00;
          end
        end
        WAIT_DONE: begin
          if (!busy_s) begin
            grant   <= 2'b00;
            rr_last <= grant[1];
          end
        end
        CFG: begin
          cfg_out   <= cfg_in;
          cfg_pulse <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef UART_SCHED_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count0 <= 16'h0000;
      count1 <= 16'h0000;
    end else if (state == WAIT_DONE && !busy_s) begin
      if (grant[0]) count0 <= count0 + 16'h0001;
      if (grant[1]) count1 <= count1 + 16'h0001;
    end
  end
`else
  assign count0 = 16'h0000;
  assign count1 = 16'h0000;
`endif

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Randomized bench for uart_tx_scheduler: two byte sources, a behavioural uart_tx,
// and a scoreboard fed by an arbitration model.
module tb_uart_tx_scheduler;

  localparam int BT = 32;
  localparam int SC = 16;

  logic        clk;
  logic        reset;
  logic        req0_valid, req1_valid;
  logic [7:0]  req0_data, req1_data;
  logic        req0_ready, req1_ready;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy;
  logic [7:0]  cfg_in, cfg_out;
  logic        cfg_pulse;
  logic [1:0]  grant;
  logic        err_timeout;
  logic [15:0] count0, count1;
  logic [2:0]  dbg_state;

  uart_tx_scheduler #(.BUSY_TIMEOUT(BT), .SETTLE_CYCLES(SC)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
    .cfg_in(cfg_in), .cfg_out(cfg_out), .cfg_pulse(cfg_pulse),
    .grant(grant), .err_timeout(err_timeout),
    .count0(count0), .count1(count1), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- scoreboard state ----------------
  int          n_checks = 0;
  int          n_errors = 0;
  logic [8:0]  exp_q[$];            // {source, byte}
  int          want0 = 0, want1 = 0, sent0 = 0, sent1 = 0;
  logic        acc0 = 1'b0, acc1 = 1'b0;
  int          emu_mode = 0;        // 0 normal, 1 busy never rises, 2 hold busy for reset
  logic        busy_held = 1'b0;
  int          frames_seen = 0;
  logic        last_srv = 1'b1;     // model: source of last completed frame
  logic [15:0] m_cnt0 = 16'h0, m_cnt1 = 16'h0;
  logic        err_exp = 1'b0;
  int          pulse_cnt = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- source drivers ----------------
  initial begin : drv0
    req0_valid = 1'b0;
    req0_data  = 8'h00;
    forever begin
      @(posedge clk); #1;
      if (acc0) begin sent0++; req0_valid = 1'b0; end
      if (!req0_valid && sent0 < want0) begin
        req0_valid = 1'b1;
        req0_data  = (sent0 == 0) ? 8'h41 : 8'($urandom_range(0, 255));
      end
    end
  end

  initial begin : drv1
    req1_valid = 1'b0;
    req1_data  = 8'h00;
    forever begin
      @(posedge clk); #1;
      if (acc1) begin sent1++; req1_valid = 1'b0; end
      if (!req1_valid && sent1 < want1) begin
        req1_valid = 1'b1;
        req1_data  = 8'($urandom_range(0, 255));
      end
    end
  end

  // ---------------- accept monitor: arbitration model pushes expectations ----------------
  always @(negedge clk) begin
    logic exp_src;
    acc0 = 1'b0;
    acc1 = 1'b0;
    if (reset && (req0_ready || req1_ready)) begin
      check("single_ready", {31'b0, req0_ready && req1_ready}, 0);
      exp_src = (req0_valid && req1_valid) ? !last_srv : req1_valid;
      check("rr_winner", {31'b0, req1_ready}, {31'b0, exp_src});
      check("ready_has_valid", {31'b0, req1_ready ? req1_valid : req0_valid}, 1);
      exp_q.push_back({exp_src, exp_src ? req1_data : req0_data});
      acc0 = req0_ready && req0_valid;
      acc1 = req1_ready && req1_valid;
    end
  end

  // ---------------- cfg monitor ----------------
  always @(negedge clk) begin
    logic [7:0] cfg_prev;
    int gap;
    logic gap_on;
    if (!reset) begin
      cfg_prev = cfg_out;
      gap_on   = 1'b0;
    end else begin
      if (cfg_pulse) begin
        pulse_cnt++;
        check("pulse_when_idle", {30'b0, grant}, 0);
        check("cfg_applied", {24'b0, cfg_out}, {24'b0, cfg_in});
        gap_on = 1'b1;
        gap    = 0;
      end else begin
        if (cfg_out !== cfg_prev) check("cfg_without_pulse", {24'b0, cfg_out}, {24'b0, cfg_prev});
        if (gap_on) begin
          gap++;
          if (grant != 2'b00) begin
            check("settle_gap", {31'b0, gap > SC}, 1);
            gap_on = 1'b0;
          end else if (gap > 1000) begin
            gap_on = 1'b0;
          end
        end
      end
      if (grant != 2'b00) check("grant_onehot", $countones(grant), 1);
      cfg_prev = cfg_out;
    end
  end

  // ---------------- behavioural uart_tx + frame checker ----------------
  initial begin : uart_model
    logic [8:0]  cur;
    logic [1:0]  exp_grant;
    logic [15:0] e0, e1;
    int n;
    tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (reset && tx_start) begin
        if (exp_q.size() == 0) begin
          check("unexpected_frame", 1, 0);
          cur = 9'h0;
        end else begin
          cur = exp_q.pop_front();
        end
        exp_grant = cur[8] ? 2'b10 : 2'b01;
        check("tx_data", {24'b0, tx_data}, {24'b0, cur[7:0]});
        check("grant", {30'b0, grant}, {30'b0, exp_grant});
        if (emu_mode == 1) begin
          n = 1;
          while (tx_start && n <= BT + 4) begin
            @(negedge clk);
            if (tx_start) n++;
          end
          check("timeout_len", n, BT);
          check("err_timeout_set", {31'b0, err_timeout}, 1);
          check("grant_after_abort", {30'b0, grant}, 0);
          err_exp = 1'b1;
        end else begin
          repeat ($urandom_range(1, 10)) @(negedge clk);
          check("start_held", {31'b0, tx_start}, 1);
          #2 tx_busy = 1'b1;
          if (emu_mode == 2) begin
            busy_held = 1'b1;
            n = 0;
            while (reset && n < 100) begin @(negedge clk); n++; end
            check("reset_seen", {31'b0, reset}, 0);
            tx_busy   = 1'b0;
            busy_held = 1'b0;
            last_srv  = 1'b1;
            m_cnt0    = 16'h0;
            m_cnt1    = 16'h0;
            err_exp   = 1'b0;
          end else begin
            n = 0;
            while (tx_start && n < 10) begin @(negedge clk); n++; end
            check("start_released", {31'b0, tx_start}, 0);
            repeat ($urandom_range(3, 20)) @(negedge clk);
            check("data_hold", {24'b0, tx_data}, {24'b0, cur[7:0]});
            check("grant_hold", {30'b0, grant}, {30'b0, exp_grant});
            #2 tx_busy = 1'b0;
            last_srv = cur[8];
            if (cur[8]) m_cnt1 = m_cnt1 + 16'h1;
            else        m_cnt0 = m_cnt0 + 16'h1;
            n = 0;
            while (grant != 2'b00 && n < 10) begin @(negedge clk); n++; end
            check("grant_cleared", {30'b0, grant}, 0);
`ifdef UART_SCHED_STATS_EN
            e0 = m_cnt0; e1 = m_cnt1;
`else
            e0 = 16'h0;  e1 = 16'h0;
`endif
            check("count0", {16'b0, count0}, {16'b0, e0});
            check("count1", {16'b0, count1}, {16'b0, e1});
          end
        end
        frames_seen++;
      end
    end
  end

  // ---------------- main sequence ----------------
  task automatic wait_frames(input int budget);
    int n;
    n = 0;
    while (frames_seen < want0 + want1 && n < budget) begin @(negedge clk); n++; end
    check("frames_drained", frames_seen, want0 + want1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_tx_start"},  {31'b0, tx_start}, 0);
    check({tag, "_grant"},     {30'b0, grant}, 0);
    check({tag, "_ready"},     {30'b0, req0_ready, req1_ready}, 0);
    check({tag, "_cfg_out"},   {24'b0, cfg_out}, 0);
    check({tag, "_cfg_pulse"}, {31'b0, cfg_pulse}, 0);
    check({tag, "_err"},       {31'b0, err_timeout}, 0);
    check({tag, "_counts"},    {count1, count0}, 0);
    check({tag, "_tx_data"},   {24'b0, tx_data}, 0);
    check({tag, "_state"},     {29'b0, dbg_state}, 0);
  endtask

  initial begin : main
    int n, p0;
    reset  = 1'b0;
    cfg_in = 8'h00;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    #2 reset = 1'b1;

    // single byte 8'h41 from req0
    @(negedge clk);
    want0 = 1;
    wait_frames(500);

    // both sources loaded together: strict alternation
    @(negedge clk);
    want0 += 4;
    want1 += 4;
    wait_frames(2000);

    // random traffic
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 1) == 1) want0++;
      if ($urandom_range(0, 1) == 1) want1++;
      repeat ($urandom_range(0, 25)) @(negedge clk);
    end
    wait_frames(20000);

    // cfg change mid-frame: deferred, intermediate value ignored
    @(negedge clk);
    p0 = pulse_cnt;
    want0 += 2;
    want1 += 2;
    n = 0;
    while (grant == 2'b00 && n < 200) begin @(negedge clk); n++; end
    check("frame_started", {31'b0, grant != 2'b00}, 1);
    cfg_in = 8'h55;
    repeat (3) @(negedge clk);
    cfg_in = 8'hC0;
    wait_frames(3000);
    check("one_cfg_pass", pulse_cnt - p0, 1);
    check("cfg_out_final", {24'b0, cfg_out}, 32'hC0);

    // busy never rises: abort
    @(negedge clk);
    emu_mode = 1;
    want1 += 1;
    wait_frames(500);
    emu_mode = 0;
    repeat (3) @(negedge clk);
    check("err_sticky", {31'b0, err_timeout}, 1);

    // reset while in WAIT_DONE
    @(negedge clk);
    emu_mode = 2;
    want0 += 1;
    n = 0;
    while (!busy_held && n < 200) begin @(negedge clk); n++; end
    check("busy_held", {31'b0, busy_held}, 1);
    repeat (5) @(negedge clk);
    check("in_wait_done", {29'b0, dbg_state}, 2);
    #2 reset = 1'b0;
    #1 check_all_zero("async_reset");
    cfg_in = 8'h00;
    repeat (3) @(negedge clk);
    emu_mode = 0;
    #2 reset = 1'b1;
    @(negedge clk);
    want0 += 1;
    want1 += 1;
    wait_frames(1000);

    repeat (5) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    check("err_final", {31'b0, err_timeout}, {31'b0, err_exp});
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
